// File: rtl/rr_interval_extractor.sv
// rtl/rr_interval_extractor.sv - R-peak pulses to gated 8-bit RR-interval samples
//
// Measures the time between R-peak rising edges in ticks of PRESCALE clk cycles.
// Only intervals within [RR_MIN, RR_MAX] are passed downstream. Anything else is
// flagged as a reject. Losing the beat for 255 ticks raises a timeout.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   enable     measurement enable; low forces IDLE and clears the counters
//   peak_in    asynchronous R-peak level; each rising edge is one beat
//   rr_out     last accepted RR interval in ticks, held until the next accept
//   rr_valid   one-cycle strobe, rr_out updated this cycle
//   rr_reject  one-cycle strobe, edge rejected (refractory or over RR_MAX)
//   timeout    one-cycle strobe, no beat for 255 ticks
//   measuring  high while in MEASURE
module rr_interval_extractor #(
    parameter int PRESCALE = 10,
    parameter int RR_MIN   = 30,
    parameter int RR_MAX   = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       peak_in,
    output logic [7:0] rr_out,
    output logic       rr_valid,
    output logic       rr_reject,
    output logic       timeout,
    output logic       measuring
);

    localparam int PW = $clog2(PRESCALE);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t        state, state_n;
    logic          s1, s2, s3;
    logic          pe;
    logic [PW-1:0] pre_cnt, pre_n;
    logic [7:0]    rr_cnt, rr_n;
    logic [7:0]    rr_out_n;
    logic          rr_valid_n, rr_reject_n, timeout_n;
    logic          tick;

    // Two flops resynchronise the input. The third flop holds the previous level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= peak_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pe   = s2 & ~s3;
    assign tick = (pre_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            rr_cnt    <= '0;
            rr_out    <= '0;
            rr_valid  <= 1'b0;
            rr_reject <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            pre_cnt   <= pre_n;
            rr_cnt    <= rr_n;
            rr_out    <= rr_out_n;
            rr_valid  <= rr_valid_n;
            rr_reject <= rr_reject_n;
            timeout   <= timeout_n;
        end
    end

    // A new reference beat loads the prescaler with 1, not 0. The edge cycle is the
    // first cycle of the first tick. With this choice, N clk between edges reads as
    // floor(N / PRESCALE) ticks.
    always_comb begin
        state_n     = state;
        pre_n       = pre_cnt;
        rr_n        = rr_cnt;
        rr_out_n    = rr_out;
        rr_valid_n  = 1'b0;
        rr_reject_n = 1'b0;
        timeout_n   = 1'b0;

        case (state)
            IDLE: begin
                pre_n = '0;
                rr_n  = '0;
                if (pe && enable) begin
                    state_n = MEASURE;
                    pre_n   = PW'(1);
                end
            end

            MEASURE: begin
                pre_n = tick ? '0 : pre_cnt + PW'(1);
                rr_n  = (tick && rr_cnt != 8'd255) ? rr_cnt + 8'd1 : rr_cnt;

                if (!enable) begin
                    state_n = IDLE;
                    pre_n   = '0;
                    rr_n    = '0;
                end else if (pe) begin
                    // Comparisons use the pre-increment count, so a coincident tick is discarded on a clear.
                    if (rr_cnt < 8'(RR_MIN)) begin
                        rr_reject_n = 1'b1;
                    end else if (rr_cnt <= 8'(RR_MAX)) begin
                        rr_out_n   = rr_cnt;
                        rr_valid_n = 1'b1;
                        pre_n      = PW'(1);
                        rr_n       = '0;
                    end else begin
                        rr_reject_n = 1'b1;
                        pre_n       = PW'(1);
                        rr_n        = '0;
                    end
                end else if (rr_cnt == 8'd255) begin
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                    pre_n     = '0;
                    rr_n      = '0;
                end
            end

            default: begin
                state_n = IDLE;
                pre_n   = '0;
                rr_n    = '0;
            end
        endcase
    end

    assign measuring = (state == MEASURE);

endmodule

// File: tb/tb_rr_interval_extractor.sv
// tb/tb_rr_interval_extractor.sv - self-checking bench for rr_interval_extractor
module tb_rr_interval_extractor;

    localparam int P  = 4;
    localparam int MN = 30;
    localparam int MX = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       peak_in = 1'b0;
    logic [7:0] rr_out;
    logic       rr_valid, rr_reject, timeout, measuring;

    rr_interval_extractor #(.PRESCALE(P), .RR_MIN(MN), .RR_MAX(MX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .peak_in   (peak_in),
        .rr_out    (rr_out),
        .rr_valid  (rr_valid),
        .rr_reject (rr_reject),
        .timeout   (timeout),
        .measuring (measuring)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int got_q[$];
    int n_valid = 0;
    bit m_meas = 1'b0;
    int m_ref = 0;
    int last_k = 0;

    function automatic int enc(int c, int kind, int r);
        return c * 1024 + kind * 256 + r;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Event log: kind 1 = accept, 2 = reject, 3 = timeout, stamped with the cycle the strobe is visible.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rr_valid) begin
                got_q.push_back(enc(cyc, 1, int'(rr_out)));
                n_valid++;
            end
            if (rr_reject) got_q.push_back(enc(cyc, 2, 0));
            if (timeout)   got_q.push_back(enc(cyc, 3, 0));
            tests++;
            assert (int'(rr_valid) + int'(rr_reject) + int'(timeout) <= 1) else begin
                fails++;
                $error("FAIL strobe_onehot observed=%0d expected<=1",
                       int'(rr_valid) + int'(rr_reject) + int'(timeout));
            end
        end
    end

    // Reference model. Beats are handled by the elapsed clk count since the reference beat.
    // p is the cycle in which the edge is recognised. The strobe follows one cycle later.
    function automatic void m_flush(int now);
        if (m_meas && now >= m_ref + 255 * P + 1) begin
            exp_q.push_back(enc(m_ref + 255 * P + 1, 3, 0));
            m_meas = 1'b0;
        end
    endfunction

    function automatic void m_edge(int p);
        int t;
        if (!enable) return;
        if (m_meas && p - m_ref > 255 * P) m_flush(p);
        if (!m_meas) begin
            m_meas = 1'b1;
            m_ref  = p;
        end else begin
            t = (p - m_ref) / P;
            if (t < MN) begin
                exp_q.push_back(enc(p + 1, 2, 0));
            end else if (t <= MX) begin
                exp_q.push_back(enc(p + 1, 1, t));
                m_ref = p;
            end else begin
                exp_q.push_back(enc(p + 1, 2, 0));
                m_ref = p;
            end
        end
    endfunction

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    // Rising edge first sampled gap clk after the previous one. The pulse is two cycles wide.
    // Returns at the negedge before the strobe becomes visible.
    task automatic peak(int gap);
        int target;
        target = last_k + gap;
        while (cyc < target - 1) @(negedge clk);
        peak_in = 1'b1;
        last_k  = cyc + 1;
        m_edge(last_k + 1);
        @(negedge clk);
        @(negedge clk);
        peak_in = 1'b0;
    endtask

    task automatic check_events(string tag);
        int n;
        m_flush(cyc);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_event"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic go_idle();
        wait_cyc(1100);
        check_events("idle");
        check("idle_measuring", measuring, 1'b0);
    endtask

    initial begin
        int n0;
        int r;
        int g;

        wait_cyc(3);
        check("reset_rr_out", rr_out, 8'd0);
        check("reset_strobes", {rr_valid, rr_reject, timeout, measuring}, 4'b0000);
        rst_n  = 1'b1;
        enable = 1'b1;
        wait_cyc(5);

        // Basic 400 clk interval.
        peak(0);
        wait_cyc(1);
        check("first_measuring", measuring, 1'b1);
        peak(400);
        wait_cyc(1);
        check("basic_valid", rr_valid, 1'b1);
        check("basic_rr", rr_out, 8'd100);
        go_idle();

        // Refractory reject, then accept measured from the original beat.
        peak(0);
        peak(40);
        wait_cyc(1);
        check("refractory_reject", rr_reject, 1'b1);
        peak(360);
        wait_cyc(1);
        check("after_refr_rr", rr_out, 8'd100);
        go_idle();

        // Over-range reject re-references.
        peak(0);
        peak(804);
        wait_cyc(1);
        check("over_reject", rr_reject, 1'b1);
        peak(400);
        wait_cyc(1);
        check("after_over_rr", rr_out, 8'd100);
        go_idle();

        // Accept bounds.
        peak(0);
        peak(120);
        wait_cyc(1);
        check("min_bound_rr", rr_out, 8'd30);
        peak(800);
        wait_cyc(1);
        check("max_bound_rr", rr_out, 8'd200);
        peak(116);
        wait_cyc(1);
        check("below_min_reject", rr_reject, 1'b1);
        go_idle();

        // Timeout, then restart.
        peak(0);
        wait_cyc(1100);
        check("timeout_measuring", measuring, 1'b0);
        check_events("timeout");
        peak(0);
        peak(400);
        wait_cyc(1);
        check("restart_rr", rr_out, 8'd100);
        go_idle();

        // Nine beats give eight intervals.
        n0 = n_valid;
        peak(0);
        for (int i = 0; i < 8; i++) peak(400);
        wait_cyc(5);
        check("nine_peaks_valid", n_valid - n0, 8);
        go_idle();

        // Randomised beat train.
        peak(0);
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: g = $urandom_range(4, 119);
                1: g = $urandom_range(116, 124);
                2: g = $urandom_range(120, 800);
                3: g = $urandom_range(796, 810);
                4: g = $urandom_range(1015, 1030);
                default: g = $urandom_range(300, 500);
            endcase
            peak(g);
            if (i % 10 == 9) begin
                wait_cyc(3);
                check_events("random");
            end
        end
        go_idle();

        // Enable low: back to IDLE, rr_out kept, held-high input gives no edge on re-enable.
        peak(0);
        peak(400);
        wait_cyc(100);
        enable = 1'b0;
        m_meas = 1'b0;
        wait_cyc(3);
        check("disable_measuring", measuring, 1'b0);
        check("disable_rr_kept", rr_out, 8'd100);
        peak_in = 1'b1;
        wait_cyc(5);
        enable = 1'b1;
        wait_cyc(20);
        check("reenable_measuring", measuring, 1'b0);
        peak_in = 1'b0;
        wait_cyc(5);
        check_events("enable");

        // Asynchronous reset mid-interval.
        peak(0);
        wait_cyc(100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rr", rr_out, 8'd0);
        check("async_rst_flags", {rr_valid, rr_reject, timeout, measuring}, 4'b0000);
        m_meas = 1'b0;
        got_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(5);
        peak(0);
        wait_cyc(20);
        check("post_rst_measuring", measuring, 1'b1);
        check_events("post_rst");
        check("post_rst_rr", rr_out, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
